seg_scroll_engine: RTL and testbench

//  Parametrised successor to the fixed 3-digit FIFO/scroller/DEC2SEG chain. Buffers ASCII bytes

---
 rtl/seg_scroll_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_seg_scroll_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_engine.sv
// seg_scroll_engine: buffers ASCII bytes in a small FIFO, decodes them to
// active-low 7-segment glyphs and shifts them onto NUM_DIGITS digits, either
// one character per divider tick (scroll) or NUM_DIGITS characters per tick
// (page). Optional macro SEG_HEX_EN adds hex letter glyphs A-F / a-f.
module seg_scroll_engine #(
    parameter int NUM_DIGITS = 3,
    parameter int DEPTH      = 16,
    parameter int BASE_DIV   = 50000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [7:0]                   in_data,
    output logic                         in_ready,
    input  logic [1:0]                   rate_sel,
    input  logic                         page_mode,
    input  logic                         clean,
    output logic [7*NUM_DIGITS-1:0]      seg,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = $clog2(BASE_DIV + 1);
    localparam int SW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        SH   = 2'd2
    } state_t;

    // Byte to glyph lookup; anything unrecognised shows as a blank digit.
    function automatic logic [6:0] decode(input logic [7:0] ch);
        logic [6:0] glyph;
        glyph = 7'h7F;
        case (ch)
            8'h30: glyph = 7'h40;
            8'h31: glyph = 7'h79;
            8'h32: glyph = 7'h24;
            8'h33: glyph = 7'h30;
            8'h34: glyph = 7'h19;
            8'h35: glyph = 7'h12;
            8'h36: glyph = 7'h02;
            8'h37: glyph = 7'h78;
            8'h38: glyph = 7'h00;
            8'h39: glyph = 7'h10;
            8'h2D: glyph = 7'h3F;
`ifdef SEG_HEX_EN
            8'h41, 8'h61: glyph = 7'h08;
            8'h42, 8'h62: glyph = 7'h03;
            8'h43, 8'h63: glyph = 7'h46;
            8'h44, 8'h64: glyph = 7'h21;
            8'h45, 8'h65: glyph = 7'h06;
            8'h46, 8'h66: glyph = 7'h0E;
`endif
            default: glyph = 7'h7F;
        endcase
        return glyph;
    endfunction

    // Pointer advance with explicit wrap so any DEPTH works.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- FIFO ----------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [7:0]    rd_data_reg;
    logic          wr_en;
    logic          rd_en;

    // Full test uses the registered count, so a same-cycle read never frees a slot.
    assign in_ready   = (count_reg != CW'(DEPTH));
    assign wr_en      = in_valid && in_ready && !clean;
    assign fifo_count = count_reg;

    // Storage array without reset so it maps onto block RAM; registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= in_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointer and occupancy bookkeeping; clean empties the FIFO like reset.
    always_ff @(posedge clk) begin
        if (reset || clean) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (rd_en) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- Tick divider ----------------
    state_t        state_reg;
    state_t        state_next;
    logic [DW-1:0] div_cnt_reg;
    logic [DW-1:0] period_reg;
    logic [DW-1:0] period_sel;
    logic          tick;

    assign period_sel = DW'(BASE_DIV >> rate_sel);
    assign tick       = (div_cnt_reg == period_reg - 1'b1);

    // Free-running divider; a new rate is adopted only at a wrap seen in IDLE.
    always_ff @(posedge clk) begin
        if (reset || clean) begin
            div_cnt_reg <= '0;
            period_reg  <= period_sel;
        end else if (tick) begin
            div_cnt_reg <= '0;
            if (state_reg == IDLE) begin
                period_reg <= period_sel;
            end
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // ---------------- Control FSM ----------------
    logic          page_reg;
    logic [SW-1:0] shifted_reg;
    logic          start;
    logic          do_shift;

    // Page mode needs a full page buffered before it will consume a tick.
    assign start = tick && (page_mode ? (count_reg >= CW'(NUM_DIGITS))
                                      : (count_reg != '0));

    // State register; clean forces IDLE and so also swallows a same-cycle tick.
    always_ff @(posedge clk) begin
        if (reset || clean) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> RD -> SH, looping RD/SH for a full page.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = RD;
            RD:   state_next = SH;
            SH: begin
                if (page_reg && (shifted_reg != SW'(NUM_DIGITS - 1))) begin
                    state_next = RD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: one read strobe per RD, one display shift per SH.
    always_comb begin
        rd_en    = (state_reg == RD);
        do_shift = (state_reg == SH);
        busy     = (state_reg != IDLE);
    end

    // Mode latch and per-page shift counter, captured when a transfer starts.
    always_ff @(posedge clk) begin
        if (reset || clean) begin
            page_reg    <= 1'b0;
            shifted_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (start) begin
                page_reg    <= page_mode;
                shifted_reg <= '0;
            end
        end else if (do_shift) begin
            shifted_reg <= shifted_reg + 1'b1;
        end
    end

    // ---------------- Display ----------------
    logic [6:0] disp_reg [NUM_DIGITS];
    logic [6:0] seg_reg  [NUM_DIGITS];
    logic [6:0] glyph_in;

    assign glyph_in = decode(rd_data_reg);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_first
                // Rightmost digit takes the freshly decoded character.
                always_ff @(posedge clk) begin
                    if (reset || clean) begin
                        disp_reg[gi] <= 7'h7F;
                    end else if (do_shift) begin
                        disp_reg[gi] <= glyph_in;
                    end
                end
            end else begin : g_rest
                // Remaining digits inherit their right-hand neighbour on a shift.
                always_ff @(posedge clk) begin
                    if (reset || clean) begin
                        disp_reg[gi] <= 7'h7F;
                    end else if (do_shift) begin
                        disp_reg[gi] <= disp_reg[gi-1];
                    end
                end
            end

            // Output stage: seg lags the display register by one cycle.
            always_ff @(posedge clk) begin
                if (reset || clean) begin
                    seg_reg[gi] <= 7'h7F;
                end else begin
                    seg_reg[gi] <= disp_reg[gi];
                end
            end

            assign seg[7*gi +: 7] = seg_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_seg_scroll_engine.sv
// tb_seg_scroll_engine: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based model of the FIFO, display and ticks.
module tb_seg_scroll_engine;

    localparam int N     = 3;
    localparam int DEPTH = 16;
    localparam int BDIV  = 8;
    localparam logic [6:0] DIGIT_GLYPH [10] =
        '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] HEX_GLYPH [6] =
        '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready;
    logic [1:0]       rate_sel = 2'd0;
    logic             page_mode = 1'b0;
    logic             clean = 1'b0;
    logic [7*N-1:0]   seg;
    logic [4:0]       fifo_count;
    logic             busy;

    seg_scroll_engine #(.NUM_DIGITS(N), .DEPTH(DEPTH), .BASE_DIV(BDIV)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rate_sel(rate_sel), .page_mode(page_mode),
        .clean(clean), .seg(seg), .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int vec_count = 0;
    int miscompares = 0;
    int cyc = 0;
    bit model_valid = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [6:0] disp_m [N];
    logic [6:0] seg_m  [N];
    int         pop_at[$];
    int         shift_at[$];
    logic [7:0] pending;
    int         busy_end;
    int         next_tick;
    int         cur_period;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        vec_count++;
        if (got !== want) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [6:0] model_glyph(input logic [7:0] ch);
        if (ch >= 8'h30 && ch <= 8'h39) return DIGIT_GLYPH[ch - 8'h30];
        if (ch == 8'h2D) return 7'h3F;
`ifdef SEG_HEX_EN
        if (ch >= 8'h41 && ch <= 8'h46) return HEX_GLYPH[ch - 8'h41];
        if (ch >= 8'h61 && ch <= 8'h66) return HEX_GLYPH[ch - 8'h61];
`endif
        return 7'h7F;
    endfunction

    function automatic logic [7*N-1:0] pack_seg();
        logic [7*N-1:0] r;
        for (int i = 0; i < N; i++) r[7*i +: 7] = seg_m[i];
        return r;
    endfunction

    // Advance the model across the edge ending cycle cyc, using current inputs.
    task automatic model_edge();
        int c;
        int pre;
        int k;
        c = cyc;
        if (reset || clean) begin
            if (reset) model_valid = 1;
            q.delete();
            pop_at.delete();
            shift_at.delete();
            for (int i = 0; i < N; i++) begin
                disp_m[i] = 7'h7F;
                seg_m[i]  = 7'h7F;
            end
            busy_end   = c;
            cur_period = BDIV >> rate_sel;
            next_tick  = c + cur_period;
        end else begin
            pre = q.size();
            seg_m = disp_m;
            if (shift_at.size() > 0 && shift_at[0] == c) begin
                void'(shift_at.pop_front());
                for (int i = N - 1; i > 0; i--) disp_m[i] = disp_m[i-1];
                disp_m[0] = model_glyph(pending);
            end
            if (pop_at.size() > 0 && pop_at[0] == c) begin
                void'(pop_at.pop_front());
                pending = q.pop_front();
            end
            if (in_valid && pre < DEPTH) q.push_back(in_data);
            if (c == next_tick) begin
                if (c > busy_end) begin
                    k = page_mode ? N : 1;
                    if (pre >= k) begin
                        for (int j = 0; j < k; j++) begin
                            pop_at.push_back(c + 1 + 2*j);
                            shift_at.push_back(c + 2 + 2*j);
                        end
                        busy_end = c + 2*k;
                    end
                    cur_period = BDIV >> rate_sel;
                end
                next_tick = c + cur_period;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (model_valid) begin
            check_value("seg", seg, pack_seg());
            check_value("fifo_count", fifo_count, q.size());
            check_value("in_ready", in_ready, q.size() < DEPTH);
            check_value("busy", busy, cyc <= busy_end);
        end
    endtask

    task automatic write_byte(input logic [7:0] ch);
        in_valid = 1'b1;
        in_data  = ch;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clean();
        clean = 1'b1;
        step();
        clean = 1'b0;
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 15);
        if (r <= 9) return 8'h30 + 8'(r);
        if (r == 10) return 8'h2D;
        if (r == 11) return 8'h20;
        if (r == 12) return 8'h41 + 8'($urandom_range(0, 5));
        if (r == 13) return 8'h61 + 8'($urandom_range(0, 5));
        if (r == 14) return 8'($urandom);
        return 8'h5A;
    endfunction

    initial begin
        int n;
        int busy_cycles;
        logic [6:0] a_glyph;

        @(posedge clk);
        #1;

        // T1: reset
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_value("t1_seg", seg, {(7*N){1'b1}});
        check_value("t1_count", fifo_count, 0);
        check_value("t1_ready", in_ready, 1);
        check_value("t1_busy", busy, 0);
        $display("T1 reset: seg=%h count=%0d", seg, fifo_count);

        // T2: scroll "123"
        write_byte(8'h31);
        write_byte(8'h32);
        write_byte(8'h33);
        repeat (40) step();
        check_value("t2_seg", seg, {7'h79, 7'h24, 7'h30});
        check_value("t2_count", fifo_count, 0);
        $display("T2 scroll: seg=%h", seg);

        // T3: fill to full while ticks keep popping
        pulse_clean();
        in_valid = 1'b1;
        n = 0;
        while (in_ready && n < 100) begin
            in_data = 8'h30 + 8'(n % 10);
            step();
            n++;
        end
        check_value("t3_fill_bound", n < 100, 1);
        check_value("t3_full_count", fifo_count, DEPTH);
        check_value("t3_full_ready", in_ready, 0);
        in_data = 8'h37;
        repeat (20) step();
        in_valid = 1'b0;
        $display("T3 full: count=%0d after %0d writes", fifo_count, n);

        // T4: page mode
        pulse_clean();
        page_mode = 1'b1;
        write_byte(8'h39);
        write_byte(8'h30);
        repeat (12) step();
        check_value("t4_ignored", seg, {(7*N){1'b1}});
        write_byte(8'h2D);
        busy_cycles = 0;
        repeat (20) begin
            step();
            if (busy) busy_cycles++;
        end
        check_value("t4_busy_len", busy_cycles, 2*N);
        check_value("t4_seg", seg, {7'h10, 7'h40, 7'h3F});
        page_mode = 1'b0;
        $display("T4 page: seg=%h busy_cycles=%0d", seg, busy_cycles);

        // T5: clean collides with a write and a tick
        write_byte(8'h37);
        write_byte(8'h38);
        n = 0;
        while (next_tick != cyc && n < 50) begin
            step();
            n++;
        end
        check_value("t5_tick_bound", n < 50, 1);
        clean = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h35;
        step();
        clean = 1'b0;
        in_valid = 1'b0;
        check_value("t5_count", fifo_count, 0);
        check_value("t5_seg", seg, {(7*N){1'b1}});
        check_value("t5_busy", busy, 0);
        $display("T5 clean: count=%0d busy=%0d", fifo_count, busy);

        // T6: rate_sel=2 and hex glyph
        rate_sel = 2'd2;
        pulse_clean();
        write_byte(8'h41);
        step();
        check_value("t6_fast_tick", busy, 1);
        repeat (10) step();
`ifdef SEG_HEX_EN
        a_glyph = 7'h08;
`else
        a_glyph = 7'h7F;
`endif
        check_value("t6_hex", seg[6:0], a_glyph);
        rate_sel = 2'd0;
        $display("T6 rate/hex: digit0=%h", seg[6:0]);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            in_data  = rand_char();
            clean    = ($urandom_range(0, 99) == 0);
            reset    = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) page_mode = ~page_mode;
            if ($urandom_range(0, 79) == 0) rate_sel = 2'($urandom_range(0, 3));
            step();
        end
        in_valid = 1'b0;
        clean = 1'b0;
        reset = 1'b0;
        $display("Random phase: %0d cycles", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
